// File: rtl/mod_voice_scheduler.sv
// rtl/mod_voice_scheduler.sv - time-multiplexed voice scan feeding the shared phase-modulation datapath
module mod_voice_scheduler #(
    parameter int NUM_BITS    = 32,
    parameter int NUM_VOICES  = 16,
    parameter int SAMPLE_DIV  = 2083,
    parameter int REL_SAMPLES = 4800
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                note_wr,
    input  logic [3:0]          note_idx,
    input  logic                note_gate,
    input  logic [NUM_BITS-1:0] note_word,
    input  logic                ds_ready,
    output logic [NUM_BITS-1:0] tuning_word,
    output logic                mod_enable,
    output logic [15:0]         curr_note,
    output logic [15:0]         note_enable,
    output logic                slot_valid,
    output logic                acc_en,
    output logic                frame_start,
    output logic                frame_done,
    output logic                overrun
);
    localparam int              TW        = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [3:0]      LAST_IDX  = 4'(NUM_VOICES - 1);
    localparam logic [15:0]     REL_INIT  = 16'(REL_SAMPLES);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] V_IDLE  = 2'd0;
    localparam logic [1:0] V_HELD  = 2'd1;
    localparam logic [1:0] V_REL   = 2'd2;

    logic [NUM_BITS-1:0] word_q    [16];
    logic [1:0]          vstate_q  [16];
    logic [15:0]         rel_cnt_q [16];
    logic [TW-1:0]       tick_cnt;
    logic [1:0]          state;
    logic [3:0]          idx;
    logic                issue_hit;
    logic                tick;
    logic [15:0]         wr_hit;
    logic [15:0]         rel_step;

    assign tick       = (tick_cnt == TICK_LAST);
    assign slot_valid = (state == S_ISSUE);
    assign acc_en     = slot_valid & ds_ready;
    assign frame_done = (state == S_DONE);

    // A release issue only counts when the slot was captured in release and
    // no table write touched the voice since capture; otherwise the count would drift.
    always_comb begin
        wr_hit      = '0;
        rel_step    = '0;
        note_enable = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            wr_hit[v]      = note_wr && (note_idx == 4'(v));
            note_enable[v] = (vstate_q[v] == V_HELD);
            rel_step[v]    = acc_en && (idx == 4'(v)) && !mod_enable && !issue_hit
                             && (vstate_q[v] == V_REL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < 16; v++) begin
                vstate_q[v]  <= V_IDLE;
                word_q[v]    <= '0;
                rel_cnt_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < 16; v++) begin
                if (wr_hit[v]) begin
                    if (note_gate) begin
                        vstate_q[v]  <= V_HELD;
                        word_q[v]    <= note_word;
                        rel_cnt_q[v] <= '0;
                    end else if (vstate_q[v] == V_HELD) begin
                        vstate_q[v]  <= V_REL;
                        rel_cnt_q[v] <= REL_INIT;
                    end
                end else if (rel_step[v]) begin
                    rel_cnt_q[v] <= rel_cnt_q[v] - 16'd1;
                    if (rel_cnt_q[v] == 16'd1) begin
                        vstate_q[v] <= V_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt    <= '0;
            state       <= S_WAIT;
            idx         <= '0;
            issue_hit   <= 1'b0;
            tuning_word <= '0;
            mod_enable  <= 1'b0;
            curr_note   <= '0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
            frame_start <= 1'b0;
            if (tick && state != S_WAIT) begin
                overrun <= 1'b1;
            end
            case (state)
                S_WAIT: begin
                    if (tick) begin
                        frame_start <= 1'b1;
                        idx         <= '0;
                        state       <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (vstate_q[idx] != V_IDLE) begin
                        tuning_word <= word_q[idx];
                        mod_enable  <= (vstate_q[idx] == V_HELD);
                        curr_note   <= 16'd1 << idx;
                        issue_hit   <= wr_hit[idx];
                        state       <= S_ISSUE;
                    end else if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_ISSUE: begin
                    if (wr_hit[idx]) begin
                        issue_hit <= 1'b1;
                    end
                    if (ds_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= S_SCAN;
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_voice_scheduler.sv
// tb/tb_mod_voice_scheduler.sv - self-checking bench for mod_voice_scheduler
`timescale 1ns/1ps
module tb_mod_voice_scheduler;
    localparam int NB = 32;
    localparam int SD = 40;
    localparam int RS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          note_wr = 1'b0;
    logic [3:0]    note_idx = '0;
    logic          note_gate = 1'b0;
    logic [NB-1:0] note_word = '0;
    logic          ds_ready = 1'b0;
    logic [NB-1:0] tuning_word;
    logic          mod_enable;
    logic [15:0]   curr_note;
    logic [15:0]   note_enable;
    logic          slot_valid;
    logic          acc_en;
    logic          frame_start;
    logic          frame_done;
    logic          overrun;

    mod_voice_scheduler #(.NUM_BITS(NB), .NUM_VOICES(16), .SAMPLE_DIV(SD), .REL_SAMPLES(RS)) dut (
        .clk(clk), .rst(rst), .note_wr(note_wr), .note_idx(note_idx), .note_gate(note_gate),
        .note_word(note_word), .ds_ready(ds_ready), .tuning_word(tuning_word),
        .mod_enable(mod_enable), .curr_note(curr_note), .note_enable(note_enable),
        .slot_valid(slot_valid), .acc_en(acc_en), .frame_start(frame_start),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   note;
        logic [NB-1:0] word;
        logic          me;
    } slot_t;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;

    // Reference voice table: held flag, remaining release issues, stored word.
    logic          m_held [16];
    int            m_rel  [16];
    logic [NB-1:0] m_word [16];

    slot_t got_q [$];
    int    cyc = -1;
    int    fs_cnt = 0, fd_cnt = 0, sv_cnt = 0, nz_cnt = 0, stall_cnt = 0, unstable_cnt = 0;
    int    first_fs_cyc = -1, last_fs_cyc = 0, last_len = 0, ov_gap = -1;
    logic  prev_stall = 1'b0, prev_ov = 1'b0;
    slot_t prev_slot = '0;

    always @(posedge clk) begin
        if (rst) cyc <= -1;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (frame_start) begin
            fs_cnt      <= fs_cnt + 1;
            last_fs_cyc <= cyc;
            if (first_fs_cyc < 0) first_fs_cyc <= cyc;
        end
        if (frame_done) begin
            fd_cnt   <= fd_cnt + 1;
            last_len <= cyc - last_fs_cyc + 1;
        end
        if (slot_valid) sv_cnt <= sv_cnt + 1;
        if (acc_en) got_q.push_back({curr_note, tuning_word, mod_enable});
        if (tuning_word != '0 || curr_note != '0 || mod_enable || note_enable != '0 || overrun)
            nz_cnt <= nz_cnt + 1;
        if (prev_stall && slot_t'({curr_note, tuning_word, mod_enable}) != prev_slot)
            unstable_cnt <= unstable_cnt + 1;
        if (slot_valid && !acc_en) stall_cnt <= stall_cnt + 1;
        prev_stall <= slot_valid && !acc_en;
        prev_slot  <= {curr_note, tuning_word, mod_enable};
        if (overrun && !prev_ov) ov_gap <= cyc - last_fs_cyc;
        prev_ov <= overrun;
    end

    // Downstream ready generator: 0 always-ready, 1 never, 2 random (max 4 stalls/frame), 3 stall voice 5 for 4 cycles.
    initial begin
        int stall_left;
        int stall_k;
        stall_left = 0;
        stall_k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (frame_start) begin
                stall_left = 4;
                stall_k = 0;
            end
            case (rdy_mode)
                0: ds_ready = 1'b1;
                1: ds_ready = 1'b0;
                2: if (slot_valid && stall_left > 0 && $urandom_range(2) == 0) begin
                       ds_ready = 1'b0;
                       stall_left--;
                   end else ds_ready = 1'b1;
                default: if (slot_valid && curr_note == 16'h0020 && stall_k < 4) begin
                       ds_ready = 1'b0;
                       stall_k++;
                   end else ds_ready = 1'b1;
            endcase
        end
    end

    task automatic model_clear();
        for (int v = 0; v < 16; v++) begin
            m_held[v] = 1'b0;
            m_rel[v]  = 0;
            m_word[v] = '0;
        end
    endtask

    task automatic do_write(input int idx, input logic gate, input logic [NB-1:0] word);
        #1;
        note_wr   = 1'b1;
        note_idx  = 4'(idx);
        note_gate = gate;
        note_word = word;
        @(posedge clk);
        #1;
        note_wr = 1'b0;
        if (gate) begin
            m_held[idx] = 1'b1;
            m_rel[idx]  = 0;
            m_word[idx] = word;
        end else if (m_held[idx]) begin
            m_held[idx] = 1'b0;
            m_rel[idx]  = RS;
        end
    endtask

    task automatic wait_frame(output int len);
        int  base;
        bit  done;
        base = fd_cnt;
        done = 0;
        for (int i = 0; i < 4 * SD && !done; i++) begin
            @(posedge clk);
            if (fd_cnt != base) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL frame_timeout got=no frame_done exp=frame_done within %0d cycles", 4 * SD);
        end
        len = last_len;
        for (int v = 0; v < 16; v++) if (m_rel[v] > 0) m_rel[v]--;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tuning_word, curr_note, mod_enable} !== '0) begin
            errors++;
            $display("FAIL reset_slot got=%h/%h/%b exp=0", tuning_word, curr_note, mod_enable);
        end
        checks++;
        if ({slot_valid, acc_en, frame_start, frame_done, overrun, note_enable} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b%b%b%b%b ne=%h exp=0", slot_valid, acc_en, frame_start, frame_done, overrun, note_enable);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    task automatic test_idle_frames();
        int b_fs, b_fd, b_sv, b_nz;
        b_fs = fs_cnt; b_fd = fd_cnt; b_sv = sv_cnt; b_nz = nz_cnt;
        rdy_mode = 0;
        while (cyc < 2 * SD + 20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (fs_cnt - b_fs != 2 || fd_cnt - b_fd != 2) begin
            errors++;
            $display("FAIL idle_frame_count got=%0d/%0d exp=2/2", fs_cnt - b_fs, fd_cnt - b_fd);
        end
        checks++;
        if (first_fs_cyc != SD - 1) begin
            errors++;
            $display("FAIL first_frame_start got=%0d exp=%0d", first_fs_cyc, SD - 1);
        end
        checks++;
        if (last_len != 17) begin
            errors++;
            $display("FAIL idle_frame_len got=%0d exp=17", last_len);
        end
        checks++;
        if (sv_cnt != b_sv || nz_cnt != b_nz) begin
            errors++;
            $display("FAIL idle_outputs got=valid:%0d nonzero:%0d exp=0/0", sv_cnt - b_sv, nz_cnt - b_nz);
        end
    endtask

    task automatic test_single_voice();
        int    base, len;
        slot_t exp_s;
        rdy_mode = 0;
        do_write(3, 1'b1, 32'h0123_4567);
        @(negedge clk);
        checks++;
        if (note_enable !== 16'h0008) begin
            errors++;
            $display("FAIL single_note_enable got=%h exp=0008", note_enable);
        end
        exp_s = {16'h0008, 32'h0123_4567, 1'b1};
        for (int f = 0; f < 2; f++) begin
            base = got_q.size();
            wait_frame(len);
            checks++;
            if (got_q.size() - base != 1) begin
                errors++;
                $display("FAIL single_issue_count got=%0d exp=1", got_q.size() - base);
            end else begin
                checks++;
                if (got_q[base] !== exp_s) begin
                    errors++;
                    $display("FAIL single_slot got=%h exp=%h", got_q[base], exp_s);
                end
            end
            checks++;
            if (len != 18) begin
                errors++;
                $display("FAIL single_frame_len got=%0d exp=18", len);
            end
        end
    endtask

    task automatic test_release();
        int    base, len, total;
        slot_t exp_s;
        total = 0;
        do_write(3, 1'b0, 32'hdead_beef);
        @(negedge clk);
        checks++;
        if (note_enable !== 16'h0000) begin
            errors++;
            $display("FAIL release_note_enable got=%h exp=0000", note_enable);
        end
        exp_s = {16'h0008, 32'h0123_4567, 1'b0};
        for (int f = 0; f < RS + 2; f++) begin
            base = got_q.size();
            wait_frame(len);
            total += got_q.size() - base;
            checks++;
            if (got_q.size() - base != ((f < RS) ? 1 : 0)) begin
                errors++;
                $display("FAIL release_frame%0d_count got=%0d exp=%0d", f, got_q.size() - base, (f < RS) ? 1 : 0);
            end else if (f < RS) begin
                checks++;
                if (got_q[base] !== exp_s) begin
                    errors++;
                    $display("FAIL release_slot got=%h exp=%h", got_q[base], exp_s);
                end
            end
        end
        checks++;
        if (total != RS) begin
            errors++;
            $display("FAIL release_total got=%0d exp=%0d", total, RS);
        end
    endtask

    task automatic test_backpressure();
        int            base, len, b_st, b_un;
        logic [NB-1:0] w [3];
        int            vs [3];
        slot_t         exp_s;
        vs[0] = 0; vs[1] = 5; vs[2] = 15;
        for (int k = 0; k < 3; k++) begin
            w[k] = $urandom;
            do_write(vs[k], 1'b1, w[k]);
        end
        rdy_mode = 3;
        base = got_q.size();
        b_st = stall_cnt;
        b_un = unstable_cnt;
        wait_frame(len);
        checks++;
        if (got_q.size() - base != 3) begin
            errors++;
            $display("FAIL bp_issue_count got=%0d exp=3", got_q.size() - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp_s = {16'(1 << vs[k]), w[k], 1'b1};
                checks++;
                if (got_q[base + k] !== exp_s) begin
                    errors++;
                    $display("FAIL bp_slot%0d got=%h exp=%h", k, got_q[base + k], exp_s);
                end
            end
        end
        checks++;
        if (len != 16 + 3 + 1 + 4) begin
            errors++;
            $display("FAIL bp_frame_len got=%0d exp=%0d", len, 16 + 3 + 1 + 4);
        end
        checks++;
        if (stall_cnt - b_st != 4 || unstable_cnt != b_un) begin
            errors++;
            $display("FAIL bp_stall got=stalls:%0d changes:%0d exp=4/0", stall_cnt - b_st, unstable_cnt - b_un);
        end
        rdy_mode = 0;
    endtask

    task automatic test_random();
        int          base, len, nw;
        slot_t       exp_q [$];
        logic [15:0] exp_ne;
        rdy_mode = 2;
        for (int f = 0; f < 10; f++) begin
            nw = $urandom_range(2);
            for (int k = 0; k < nw; k++)
                do_write($urandom_range(15), 1'($urandom_range(1)), $urandom);
            exp_q.delete();
            exp_ne = '0;
            for (int v = 0; v < 16; v++) begin
                exp_ne[v] = m_held[v];
                if (m_held[v] || m_rel[v] > 0)
                    exp_q.push_back({16'(1 << v), m_word[v], m_held[v]});
            end
            @(negedge clk);
            checks++;
            if (note_enable !== exp_ne) begin
                errors++;
                $display("FAIL rand%0d_note_enable got=%h exp=%h", f, note_enable, exp_ne);
            end
            base = got_q.size();
            wait_frame(len);
            checks++;
            if (got_q.size() - base != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_issue_count got=%0d exp=%0d", f, got_q.size() - base, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (got_q[base + i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand%0d_slot%0d got=%h exp=%h", f, i, got_q[base + i], exp_q[i]);
                    end
                end
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_overrun();
        int n, b_fs;
        rdy_mode = 1;
        for (int v = 0; v < 16; v++) do_write(v, 1'b1, $urandom);
        n = 0;
        while (!slot_valid && n < 3 * SD) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!overrun && n < 3 * SD) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (ov_gap != SD) begin
            errors++;
            $display("FAIL overrun_timing got=%0d exp=%0d cycles after frame_start", ov_gap, SD);
        end
        b_fs = fs_cnt;
        repeat (3 * SD) @(posedge clk);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1 || slot_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got=ovr:%b valid:%b exp=1/1", overrun, slot_valid);
        end
        checks++;
        if (fs_cnt != b_fs) begin
            errors++;
            $display("FAIL overrun_skip got=%0d new frames exp=0", fs_cnt - b_fs);
        end
    endtask

    task automatic test_reset_mid();
        int b_fd, base, len;
        b_fd = fd_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({slot_valid, acc_en, mod_enable, overrun, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL rst_async_ctrl got=%b%b%b%b%b exp=00000", slot_valid, acc_en, mod_enable, overrun, frame_done);
        end
        checks++;
        if ({tuning_word, curr_note, note_enable} !== '0) begin
            errors++;
            $display("FAIL rst_async_data got=%h/%h/%h exp=0", tuning_word, curr_note, note_enable);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (fd_cnt != b_fd) begin
            errors++;
            $display("FAIL rst_no_done got=%0d exp=0", fd_cnt - b_fd);
        end
        rdy_mode = 0;
        base = got_q.size();
        wait_frame(len);
        checks++;
        if (got_q.size() != base || note_enable !== 16'h0000) begin
            errors++;
            $display("FAIL rst_table_idle got=issues:%0d ne:%h exp=0/0000", got_q.size() - base, note_enable);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_idle_frames();
        test_single_voice();
        test_release();
        test_backpressure();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
